// File: rtl/sfx_pkg.sv
// Shared types for the sound-effect sequencer: frame layout, FSM states and
// the saturating VCO sweep step.
package sfx_pkg;

  localparam int VCO_W   = 12;
  localparam int NOISE_W = 12;
  localparam int LFO_W   = 10;
  localparam int DUR_W   = 8;
  localparam int SWEEP_W = 8;

  typedef struct packed {
    logic [DUR_W-1:0]   dur;
    logic [VCO_W-1:0]   vco_freq;
    logic [SWEEP_W-1:0] vco_sweep;
    logic [NOISE_W-1:0] noise_freq;
    logic [LFO_W-1:0]   lfo_freq;
    logic [2:0]         lfo_shift;
    logic               vco_select;
    logic               noise_select;
    logic [2:0]         mixer;
  } sfx_frame_t;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} sfx_state_e;

  // Two guard bits: 4095 + 127 must not wrap negative before the clamp.
  function automatic logic [VCO_W-1:0] sweep_clamp(input logic [VCO_W-1:0]   freq,
                                                   input logic [SWEEP_W-1:0] delta);
    logic signed [VCO_W+1:0] sum;
    sum = $signed({2'b00, freq}) +
          $signed({{(VCO_W+2-SWEEP_W){delta[SWEEP_W-1]}}, delta});
    if (sum < 0)
      return '0;
    else if (sum > $signed({2'b00, {VCO_W{1'b1}}}))
      return '1;
    else
      return sum[VCO_W-1:0];
  endfunction

endpackage

// File: rtl/sfx_frame_fifo.sv
// Frame queue between the host handshake and the sequencer FSM.
// Extra pointer bit distinguishes full from empty.
module sfx_frame_fifo
  import sfx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  sfx_frame_t din_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic       full_o,
  output logic       empty_o,
  output sfx_frame_t head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, rd_q;
  sfx_frame_t  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/sfx_sequencer.sv
// Plays queued parameter frames into sound_generator, one frame per
// programmed tick count, with optional linear VCO sweep and mute on drain.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int TICK_DIV = 416667,
  parameter int DEPTH    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [DUR_W-1:0]   cmd_dur_i,
  input  logic [VCO_W-1:0]   cmd_vco_freq_i,
  input  logic [SWEEP_W-1:0] cmd_vco_sweep_i,
  input  logic [NOISE_W-1:0] cmd_noise_freq_i,
  input  logic [LFO_W-1:0]   cmd_lfo_freq_i,
  input  logic [2:0]         cmd_lfo_shift_i,
  input  logic               cmd_vco_select_i,
  input  logic               cmd_noise_select_i,
  input  logic [2:0]         cmd_mixer_i,
  input  logic               abort_i,
  output logic [VCO_W-1:0]   vco_freq_o,
  output logic [NOISE_W-1:0] noise_freq_o,
  output logic [LFO_W-1:0]   lfo_freq_o,
  output logic [2:0]         lfo_shift_o,
  output logic               vco_select_o,
  output logic               noise_select_o,
  output logic [2:0]         mixer_o,
  output logic               busy_o,
  output logic               frame_tick_o
);
  // state | meaning
  // IDLE  | nothing playing, mixer muted, other parameters held
  // LOAD  | pop head frame into the output registers (ticks ignored)
  // PLAY  | count ticks down, sweep VCO, chain or mute on expiry

  localparam int            PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == TC);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) presc_q <= '0;
    else         presc_q <= presc_d;
  end

  sfx_state_e         state_q;
  logic [DUR_W-1:0]   rem_q;
  logic [SWEEP_W-1:0] sweep_q;
  logic [VCO_W-1:0]   vco_q;
  logic [NOISE_W-1:0] noise_q;
  logic [LFO_W-1:0]   lfo_q;
  logic [2:0]         shift_q, mixer_q;
  logic               vsel_q, nsel_q;

  logic       full, empty, push, pop;
  sfx_frame_t cmd_frame, head;

  assign cmd_ready_o = !full && !abort_i && rst_ni;
  // Zero-duration frames are handshaken but never enter the queue.
  assign push = cmd_valid_i && cmd_ready_o && (cmd_dur_i != '0);
  assign pop  = (state_q == LOAD) && !abort_i;

  assign cmd_frame = '{dur:          cmd_dur_i,
                       vco_freq:     cmd_vco_freq_i,
                       vco_sweep:    cmd_vco_sweep_i,
                       noise_freq:   cmd_noise_freq_i,
                       lfo_freq:     cmd_lfo_freq_i,
                       lfo_shift:    cmd_lfo_shift_i,
                       vco_select:   cmd_vco_select_i,
                       noise_select: cmd_noise_select_i,
                       mixer:        cmd_mixer_i};

  sfx_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .din_i   (cmd_frame),
    .pop_i   (pop),
    .flush_i (abort_i),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sweep_q <= '0;
      vco_q   <= '0;
      noise_q <= '0;
      lfo_q   <= '0;
      shift_q <= '0;
      vsel_q  <= 1'b0;
      nsel_q  <= 1'b0;
      mixer_q <= '0;
    end else if (abort_i) begin
      state_q <= IDLE;
      mixer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mixer_q <= '0;
          if (!empty) state_q <= LOAD;
        end
        LOAD: begin
          rem_q   <= head.dur;
          sweep_q <= head.vco_sweep;
          vco_q   <= head.vco_freq;
          noise_q <= head.noise_freq;
          lfo_q   <= head.lfo_freq;
          shift_q <= head.lfo_shift;
          vsel_q  <= head.vco_select;
          nsel_q  <= head.noise_select;
          mixer_q <= head.mixer;
          state_q <= PLAY;
        end
        PLAY: begin
          if (tick) begin
            if (rem_q > DUR_W'(1)) begin
              rem_q <= rem_q - 1'b1;
              vco_q <= sweep_clamp(vco_q, sweep_q);
            end else if (!empty) begin
              state_q <= LOAD;
            end else begin
              state_q <= IDLE;
              mixer_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vco_freq_o     = vco_q;
  assign noise_freq_o   = noise_q;
  assign lfo_freq_o     = lfo_q;
  assign lfo_shift_o    = shift_q;
  assign vco_select_o   = vsel_q;
  assign noise_select_o = nsel_q;
  assign mixer_o        = mixer_q;
  assign busy_o         = (state_q != IDLE) || !empty;
  assign frame_tick_o   = tick;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with a load-event scoreboard.
module tb_sfx_sequencer;
  import sfx_pkg::*;

  localparam int TD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmd_valid = 1'b0;
  logic abort = 1'b0;
  sfx_frame_t cur = '0;

  logic        cmd_ready, busy, frame_tick;
  logic [11:0] vco_freq, noise_freq;
  logic [9:0]  lfo_freq;
  logic [2:0]  lfo_shift, mixer;
  logic        vco_select, noise_select;

  sfx_sequencer #(.TICK_DIV(TD), .DEPTH(4)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .cmd_valid_i        (cmd_valid),
    .cmd_ready_o        (cmd_ready),
    .cmd_dur_i          (cur.dur),
    .cmd_vco_freq_i     (cur.vco_freq),
    .cmd_vco_sweep_i    (cur.vco_sweep),
    .cmd_noise_freq_i   (cur.noise_freq),
    .cmd_lfo_freq_i     (cur.lfo_freq),
    .cmd_lfo_shift_i    (cur.lfo_shift),
    .cmd_vco_select_i   (cur.vco_select),
    .cmd_noise_select_i (cur.noise_select),
    .cmd_mixer_i        (cur.mixer),
    .abort_i            (abort),
    .vco_freq_o         (vco_freq),
    .noise_freq_o       (noise_freq),
    .lfo_freq_o         (lfo_freq),
    .lfo_shift_o        (lfo_shift),
    .vco_select_o       (vco_select),
    .noise_select_o     (noise_select),
    .mixer_o            (mixer),
    .busy_o             (busy),
    .frame_tick_o       (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [41:0] exp_q[$];
  logic [41:0] obs;
  assign obs = {vco_freq, noise_freq, lfo_freq, lfo_shift, vco_select, noise_select, mixer};

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  function automatic logic [41:0] pars_of(input sfx_frame_t f);
    return {f.vco_freq, f.noise_freq, f.lfo_freq, f.lfo_shift, f.vco_select, f.noise_select, f.mixer};
  endfunction

  function automatic sfx_frame_t mk(input int dur, input int vco, input int sw, input int noise,
                                    input int lfo, input int sh, input int vs, input int ns, input int mix);
    sfx_frame_t f;
    f.dur = 8'(dur);          f.vco_freq = 12'(vco);   f.vco_sweep = 8'(sw);
    f.noise_freq = 12'(noise); f.lfo_freq = 10'(lfo);  f.lfo_shift = 3'(sh);
    f.vco_select = 1'(vs);    f.noise_select = 1'(ns); f.mixer = 3'(mix);
    return f;
  endfunction

  // Scoreboard monitor: one negedge after a LOAD cycle the outputs must show the next queued frame.
  bit pend = 1'b0;
  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL load_unexpected: got %0h expected no load", obs);
      end else begin
        check("load_params", obs, exp_q.pop_front());
      end
    end
    pend = rst_n && (dut.state_q == LOAD);
  end

  // Called at a negedge; returns at the negedge after the accepting edge with cmd_valid still high.
  task automatic send(input sfx_frame_t f, output int waits);
    cur = f;
    cmd_valid = 1'b1;
    waits = 0;
    while (!cmd_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end else if (f.dur != 0) begin
      exp_q.push_back(pars_of(f));
    end
    @(negedge clk);
  endtask

  task automatic lat_check(input string nm);
    int n = 0;
    while (mixer == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, n, 2);
  endtask

  // Records vco_freq just before every tick edge while the frame is audible.
  task automatic watch(input string nm, input logic [11:0] ev[$], input bit exp_idle);
    logic [11:0] got[$];
    int n = 0;
    while (mixer == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (mixer != 0 && n < 2000) begin
      if (frame_tick) got.push_back(vco_freq);
      @(negedge clk);
      n++;
    end
    check({nm, "_ticks"}, got.size(), ev.size());
    foreach (ev[i]) if (i < got.size()) check({nm, "_vco"}, got[i], ev[i]);
    if (exp_idle) check({nm, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    int w, n, cnt;
    int ws[6];
    sfx_frame_t fr[6];
    logic [41:0] snap;

    #1 rst_n = 1'b0;
    #1;
    check("rst_params", obs, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_tick", frame_tick, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_rst", cmd_ready, 1);

    // Prescaler period
    @(negedge clk);
    n = 0;
    while (!frame_tick && n < 20) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_tick && n < 20);
    check("tick_period", n, TD);

    // Single frame
    send(mk(3, 250, 0, 100, 5, 2, 1, 0, 3), w);
    cmd_valid = 1'b0;
    check("single_mixer_e0", mixer, 0);
    lat_check("single_latency");
    watch("single", '{12'd250, 12'd250, 12'd250}, 1'b1);

    // Sweep down clamps at 0
    send(mk(5, 10, 8'hFC, 1, 2, 3, 0, 1, 1), w);
    cmd_valid = 1'b0;
    watch("sweep_dn", '{12'd10, 12'd6, 12'd2, 12'd0, 12'd0}, 1'b1);

    // Sweep up clamps at 4095
    send(mk(3, 4090, 7, 2, 3, 4, 1, 1, 2), w);
    cmd_valid = 1'b0;
    watch("sweep_up", '{12'd4090, 12'd4095, 12'd4095}, 1'b1);

    // Queue fill: first frame is popped by LOAD, then four more fill the queue; the sixth stalls
    for (int i = 0; i < 6; i++) fr[i] = mk(2, 300 + i, 0, 10 + i, 20 + i, i, i % 2, (i + 1) % 2, i + 1);
    for (int i = 0; i < 6; i++) send(fr[i], ws[i]);
    cmd_valid = 1'b0;
    check("fill_no_stall", ws[0] + ws[1] + ws[2] + ws[3] + ws[4], 0);
    check_rng("fill_sixth_stalls", ws[5], 1, 100);
    cnt = 0;
    n = 0;
    while (busy && n < 500) begin
      if (mixer == 0) cnt++;
      @(negedge clk);
      n++;
    end
    check("fill_mute_gaps", cnt, 0);
    check("fill_drained_mixer", mixer, 0);
    check("fill_all_played", exp_q.size(), 0);

    // Abort mid-PLAY with two frames queued
    send(mk(20, 500, 0, 7, 7, 1, 0, 0, 5), w);
    send(mk(3, 600, 0, 8, 8, 2, 1, 0, 4), w);
    send(mk(3, 700, 0, 9, 9, 3, 0, 1, 6), w);
    cmd_valid = 1'b0;
    n = 0;
    while (mixer == 0 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("abort_pre_busy", busy, 1);
    abort = 1'b1;
    #1 check("abort_ready", cmd_ready, 0);
    exp_q.delete();
    @(negedge clk);
    check("abort_mixer", mixer, 0);
    check("abort_busy", busy, 0);
    abort = 1'b0;
    #1 check("abort_ready_back", cmd_ready, 1);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (mixer != 0 || busy) cnt++; end
    check("abort_queue_empty", cnt, 0);
    send(mk(2, 77, 0, 11, 12, 5, 1, 1, 7), w);
    cmd_valid = 1'b0;
    lat_check("post_abort_latency");
    watch("post_abort", '{12'd77, 12'd77}, 1'b1);

    // Zero-duration frame is consumed without effect
    snap = obs;
    send(mk(0, 999, 0, 55, 66, 7, 0, 0, 7), w);
    cmd_valid = 1'b0;
    check("dur0_accepted", w, 0);
    cnt = 0;
    repeat (6) begin if (busy) cnt++; @(negedge clk); end
    check("dur0_busy", cnt, 0);
    check("dur0_params", obs, snap);

    // Async reset mid-frame
    send(mk(10, 1234, 0, 321, 111, 6, 1, 1, 6), w);
    cmd_valid = 1'b0;
    n = 0;
    while (mixer == 0 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_params", obs, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", cmd_ready, 0);
    check("arst_tick", frame_tick, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin @(negedge clk); if (mixer != 0 || busy) cnt++; end
    check("arst_no_resume", cnt, 0);

    check("end_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
